// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan decoder: FSM states,
// segment bit positions and the hex glyph table.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CAPTURE,
    HOLD
  } state_t;

  localparam int SEL_W = 4;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Entry k is the active-high a..g pattern that displays hex digit k.
  localparam logic [15:0][6:0] GLYPH = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic is_onehot(input logic [SEL_W-1:0] s);
    return (s != '0) && ((s & (s - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational 7-segment pattern to hex nibble decoder; legal=0 for any
// pattern that is not one of the 16 hex glyphs.
module seg_glyph_decode
  import seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       legal,
  output logic [3:0] nibble
);

  always_comb begin
    // NOTE: every output gets a default before the search loop so no path
    // through the block leaves it unassigned, which would infer a latch.
    legal  = 1'b0;
    nibble = 4'h0;
    for (int k = 0; k < 16; k++) begin
      if (pattern == GLYPH[k]) begin
        legal  = 1'b1;
        nibble = 4'(k);
      end
    end
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Receive-side monitor for a 4-digit multiplexed 7-segment scan. Define
// SEG_SCAN_SYNC_EN to add 2-flop input synchronizers for asynchronous pins.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  sel,
  input  logic [7:0]  seg,
  output logic [15:0] value,
  output logic [3:0]  dp,
  output logic [3:0]  valid,
  output logic        frame_done,
  output logic        sel_err,
  output logic        stale
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_MAX  = SW'(SETTLE_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

  logic [SEL_W-1:0] sel_s;
  logic [7:0]       seg_s;

`ifdef SEG_SCAN_SYNC_EN
  logic [11:0] sync1, sync2;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {sel, seg};
      sync2 <= sync1;
    end
  end
  assign {sel_s, seg_s} = sync2;
`else
  assign sel_s = sel;
  assign seg_s = seg;
`endif

  logic [11:0]   prev;
  logic          changed;
  logic [SW-1:0] settle_cnt, settle_next;
  logic [TW-1:0] tcnt;
  logic [3:0]    mask;
  state_t        state, state_next;

  assign changed = ({sel_s, seg_s} != prev);

  always_comb begin
    settle_next = settle_cnt;
    if (changed)                       settle_next = '0;
    else if (settle_cnt != SETTLE_MAX) settle_next = settle_cnt + 1'b1;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (sel_s != '0) state_next = SETTLE;
      SETTLE: begin
        if (sel_s == '0)                    state_next = IDLE;
        else if (settle_next == SETTLE_MAX) state_next = CAPTURE;
      end
      CAPTURE: state_next = HOLD;
      HOLD:    if (changed) state_next = (sel_s == '0) ? IDLE : SETTLE;
      default: state_next = IDLE;
    endcase
  end

  logic       legal, onehot;
  logic [3:0] nibble;
  logic [1:0] idx;

  seg_glyph_decode u_decode (
    .pattern (seg_s[SEG_G:SEG_A]),
    .legal   (legal),
    .nibble  (nibble)
  );

  always_comb begin
    onehot = is_onehot(sel_s);
    idx    = 2'd0;
    for (int k = 0; k < SEL_W; k++) begin
      if (sel_s[k]) idx = 2'(k);
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      prev       <= '0;
      settle_cnt <= '0;
      tcnt       <= '0;
      mask       <= '0;
      value      <= '0;
      dp         <= '0;
      valid      <= '0;
      frame_done <= 1'b0;
      sel_err    <= 1'b0;
    end else begin
      state      <= state_next;
      prev       <= {sel_s, seg_s};
      settle_cnt <= settle_next;
      frame_done <= 1'b0;
      sel_err    <= 1'b0;

      // Frame completion takes priority over the timeout reaching its limit.
      if (mask == 4'hF) begin
        mask       <= '0;
        frame_done <= 1'b1;
        tcnt       <= '0;
      end else begin
        if (state == CAPTURE && onehot) mask[idx] <= 1'b1;
        if (tcnt != TIMEOUT_MAX) tcnt <= tcnt + 1'b1;
      end

      if (state == CAPTURE) begin
        if (onehot) begin
          valid[idx] <= legal;
          dp[idx]    <= seg_s[SEG_DP];
          if (legal) value[4*idx +: 4] <= nibble;
        end else begin
          sel_err <= 1'b1;
        end
      end
    end
  end

  assign stale = (tcnt == TIMEOUT_MAX);

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: stimulus queues the expected output
// snapshot for each frame_done / sel_err event, a monitor pops and compares.
module tb_seg_scan_decoder;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 1000;
  localparam int SLOT    = 250;

  typedef struct packed {
    logic        is_err;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  valid;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  sel;
  logic [7:0]  seg;
  logic [15:0] value;
  logic [3:0]  dp, valid;
  logic        frame_done, sel_err, stale;

  int  n_cmp = 0;
  int  n_err = 0;
  ev_t exp_q[$];
  ev_t got_ev, exp_ev;

  seg_scan_decoder #(
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sel        (sel),
    .seg        (seg),
    .value      (value),
    .dp         (dp),
    .valid      (valid),
    .frame_done (frame_done),
    .sel_err    (sel_err),
    .stale      (stale)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Drive one {sel,seg} pair for n cycles; called at posedge+1.
  task automatic drive(input logic [3:0] s, input logic [7:0] g, input int n);
    sel = s;
    seg = g;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_ev(input logic is_err, input logic [15:0] v,
                           input logic [3:0] d, input logic [3:0] vl);
    ev_t e;
    e.is_err = is_err;
    e.value  = v;
    e.dp     = d;
    e.valid  = vl;
    exp_q.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_value"}, 32'(value), 32'h0);
    check({tag, "_dp"}, 32'(dp), 32'h0);
    check({tag, "_valid"}, 32'(valid), 32'h0);
    check({tag, "_flags"}, {29'd0, frame_done, sel_err, stale}, 32'h0);
  endtask

  // Wait (bounded) for frame_done while the current slot keeps driving.
  task automatic wait_frame(output logic found, output logic stale_before,
                            output logic stale_at);
    found        = 1'b0;
    stale_before = 1'b0;
    stale_at     = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (frame_done) begin
        found    = 1'b1;
        stale_at = stale;
      end else begin
        stale_before = stale;
      end
    end
  endtask

  // Monitor: every event the DUT presents is matched against the queue.
  always @(negedge clk) begin
    if (!rst && (frame_done || sel_err)) begin
      got_ev = '{is_err: sel_err, value: value, dp: dp, valid: valid};
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_event: got %0h expected none", got_ev);
      end else begin
        exp_ev = exp_q.pop_front();
        check("event", 32'(got_ev), 32'(exp_ev));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic found, st_before, st_at;
    int   n;

    rst = 1'b1;
    sel = 4'h0;
    seg = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_zero("reset");

    // "1234" scanned twice: one frame_done per four slots.
    for (int f = 0; f < 2; f++) begin
      expect_ev(1'b0, 16'h1234, 4'b0000, 4'b1111);
      drive(4'b0001, 8'h66, SLOT);
      drive(4'b0010, 8'h4F, SLOT);
      drive(4'b0100, 8'h5B, SLOT);
      drive(4'b1000, 8'h06, SLOT);
    end

    // Digit1 = 5, digit2 = E with decimal point.
    expect_ev(1'b0, 16'h1E54, 4'b0100, 4'b1111);
    drive(4'b0001, 8'h66, SLOT);
    drive(4'b0010, 8'h6D, SLOT);
    drive(4'b0100, 8'hF9, SLOT);
    drive(4'b1000, 8'h06, SLOT);

    // Digit1 illegal: nibble keeps 5, valid[1] drops, frame still completes.
    expect_ev(1'b0, 16'h1254, 4'b0000, 4'b1101);
    drive(4'b0001, 8'h66, SLOT);
    drive(4'b0010, 8'h49, SLOT);
    drive(4'b0100, 8'h5B, SLOT);
    drive(4'b1000, 8'h06, SLOT);

    // Two selects active: one sel_err pulse, outputs untouched.
    expect_ev(1'b1, 16'h1254, 4'b0000, 4'b1101);
    drive(4'b0110, 8'h3F, 10);
    // Glitching every 3 cycles never settles, so no capture.
    for (int i = 0; i < 10; i++) drive(4'b0001, (i % 2) ? 8'h5B : 8'h06, 3);
    drive(4'b0000, 8'h00, 10);
    check("glitch_value", 32'(value), 32'h1254);
    check("glitch_valid", 32'(valid), 32'hD);

    // One frame, then scan stops: stale exactly TIMEOUT cycles later.
    expect_ev(1'b0, 16'h1234, 4'b0000, 4'b1111);
    drive(4'b0001, 8'h66, SLOT);
    drive(4'b0010, 8'h4F, SLOT);
    drive(4'b0100, 8'h5B, SLOT);
    sel = 4'b1000;
    seg = 8'h06;
    wait_frame(found, st_before, st_at);
    check("frame_seen", 32'(found), 32'h1);
    n = 0;
    while (n < TIMEOUT + 100 && !stale) begin
      @(negedge clk);
      n++;
    end
    check("stale_delay", 32'(n), 32'(TIMEOUT));
    @(posedge clk);
    #1;
    drive(4'b0000, 8'h00, 20);
    check("stale_held", 32'(stale), 32'h1);

    // Resumed scan: stale holds until the frame_done cycle, then clears.
    expect_ev(1'b0, 16'h1234, 4'b0000, 4'b1111);
    drive(4'b0001, 8'h66, SLOT);
    drive(4'b0010, 8'h4F, SLOT);
    drive(4'b0100, 8'h5B, SLOT);
    sel = 4'b1000;
    seg = 8'h06;
    wait_frame(found, st_before, st_at);
    check("resume_frame_seen", 32'(found), 32'h1);
    check("stale_before_frame", 32'(st_before), 32'h1);
    check("stale_at_frame", 32'(st_at), 32'h0);
    @(posedge clk);
    #1;

    // Reset after two of four digits: partial frame is discarded.
    drive(4'b0001, 8'h66, SLOT);
    drive(4'b0010, 8'h4F, SLOT);
    sel = 4'b0000;
    seg = 8'h00;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_zero("midrst");
    drive(4'b0100, 8'h77, SLOT);
    drive(4'b1000, 8'h7C, SLOT);
    check("half_value", 32'(value), 32'hBA00);
    expect_ev(1'b0, 16'hBA56, 4'b0000, 4'b1111);
    drive(4'b0001, 8'h7D, SLOT);
    drive(4'b0010, 8'h6D, SLOT);
    drive(4'b0000, 8'h00, 20);

    check("events_pending", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receive-side counterpart of the 4-digit multiplexed 7-segment driver: samples the active-high digit selects `sel[3:0]` and segment bus `seg[7:0]` produced by `Count`.
- Reconstructs the four displayed hex nibbles and decimal points.
- Flags unrecognised patterns and reports frame completion and scan stalls.
- Used as an on-chip loopback monitor and as the scoreboard front end in display benches.

Parameters:
- SETTLE_CYCLES, 4, consecutive cycles `{sel,seg}` must be unchanged before a sample is taken (>=1).
- TIMEOUT_CYCLES, 1_000_000, cycles without a completed frame before `stale` asserts (>=2).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- sel  in  4  digit select, active-high, expected one-hot; bit0 = rightmost digit
- seg  in  8  segments, active-high; bit0..6 = a..g, bit7 = dp
- value  out  16  decoded nibbles; [3:0] = digit0 … [15:12] = digit3
- dp  out  4  captured decimal point per digit
- valid  out  4  per digit: last captured pattern was a legal hex glyph
- frame_done  out  1  one-cycle pulse when all four digits captured since last pulse
- sel_err  out  1  one-cycle pulse when `sel` is stable but not one-hot (excluding 0000)
- stale  out  1  level: no frame completed within TIMEOUT_CYCLES

Behaviour:
- Reset: `value`=0, `dp`=0, `valid`=0, `frame_done`=0, `sel_err`=0, `stale`=0; FSM=IDLE; capture mask=0; settle and timeout counters=0.
- Glyph table (`seg[6:0]` → nibble): 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9, 77→A, 7C→b, 39→C, 5E→d, 79→E, 71→F. Any other pattern, including 00, is illegal.
- Stability: register the previous `{sel,seg}`. Any difference resets the settle counter to 0; otherwise it increments, saturating at SETTLE_CYCLES.
- FSM IDLE: waits for `sel`≠0 → SETTLE.
- FSM SETTLE:
  - On the cycle the settle counter reaches SETTLE_CYCLES → CAPTURE.
  - Any change → stays in SETTLE with the counter cleared.
  - `sel`=0 → IDLE.
- FSM CAPTURE (single cycle):
  - If `sel` is one-hot, index i: the glyph's nibble loads `value[4i+3:4i]`; `valid[i]`=1 and `dp[i]`=`seg[7]`; mask[i]=1.
  - If the glyph is illegal: `valid[i]`=0, `dp[i]`=`seg[7]`, nibble held, mask[i] still set.
  - If `sel` is not one-hot: `sel_err` pulse, no output update.
  - → HOLD.
- FSM HOLD: remains until `{sel,seg}` changes → SETTLE (or IDLE if `sel`=0). Guarantees at most one capture per scan slot.
- Latency: outputs update on the clock edge ending CAPTURE, i.e. SETTLE_CYCLES+1 cycles after the last input change (+2 with the sync option).
- Frame completion:
  - When the mask becomes 1111, `frame_done` pulses the following cycle and the mask clears in the same cycle.
  - Recapturing an already-set digit does not advance the frame.
- Timeout:
  - The counter clears on `frame_done`; otherwise it increments, saturating at TIMEOUT_CYCLES.
  - `stale`=1 while the counter equals TIMEOUT_CYCLES.
  - `stale` clears on the cycle `frame_done` pulses.
- Simultaneous events: `frame_done` and the timeout reaching its limit on the same cycle → `frame_done` wins, `stale` stays 0.
- Reset mid-operation: all state returns to reset values on the next edge; a partially captured frame is discarded.
- Counter widths: `$clog2(PARAM+1)`. All arithmetic is unsigned.

Optional Feature:
- Macro: SEG_SCAN_SYNC_EN.
- With the macro defined: `sel` and `seg` each pass through a 2-flop synchronizer (reset to 0) before the stability logic, for asynchronous pin loopback. Latency +2 cycles.
- Without it: inputs feed the stability register directly. Inputs must then be synchronous to `clk`.

Decomposition:
- Shared package `seg_pkg`:
  - FSM state typedef (IDLE, SETTLE, CAPTURE, HOLD).
  - 16-entry glyph constant table.
  - Segment bit-position constants (SEG_A…SEG_G, SEG_DP).
  - Select width constant (4).
- One sub-module, `seg_glyph_decode`: combinational 7-bit pattern → {legal, nibble}. Shared with any future encoder check.

Test Plan:
- Scan "1234", 250-cycle slots, SETTLE_CYCLES=4 → `value`=16'h1234, `valid`=1111, `frame_done` pulses once per 4 slots, `sel_err` never pulses.
- Digit2 slot drives `seg`=8'hF9 (E + dp) → `value[11:8]`=4'hE, `dp[2]`=1, other `dp` bits 0.
- Digit1 slot drives illegal 8'h49 after a prior 5 → `valid[1]`=0, `value[7:4]` holds 4'h5, frame still completes.
- `sel`=4'b0110 held 10 cycles → exactly one `sel_err` pulse, outputs unchanged; `{sel,seg}` glitching every 3 cycles with SETTLE_CYCLES=4 → no capture.
- TIMEOUT_CYCLES=1000, scan stopped after one frame → `stale`=1 exactly 1000 cycles after `frame_done`; resumed scan → `stale` clears on the next `frame_done`.
- Assert `rst` for one cycle after 2 of 4 digits captured → all outputs 0; `frame_done` requires 4 fresh captures afterwards.
